pc_sequencer: RTL and testbench

Parametrised next-generation program counter for the RISC CPU datapath. It adds the following to word-step increment and PC-relative branch:
- configurable width, step and reset vector;
- absolute jump;
- call/return with an internal circular return-address stack (RAS);
- stall;
- sticky RAS error flags.

It sits in the fetch stage and drives the instruction memory address and the PC register output.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/ras_stack.sv | 57 +++++
 rtl/pc_sequencer.sv | 144 ++++++++++++++
 tb/tb_pc_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared constants and the pc_src action encoding for the fetch-stage PC sequencer.
package pc_seq_pkg;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_RAS_DEPTH    = 4;
  localparam int DEF_INC_STEP     = 1;
  localparam int DEF_RESET_VECTOR = 0;

  typedef enum logic [2:0] {
    PC_SRC_HOLD   = 3'd0,
    PC_SRC_LOAD   = 3'd1,
    PC_SRC_RET    = 3'd2,
    PC_SRC_CALL   = 3'd3,
    PC_SRC_JUMP   = 3'd4,
    PC_SRC_BRANCH = 3'd5,
    PC_SRC_INC    = 3'd6,
    PC_SRC_RESET  = 3'd7
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full,
  output logic             overflow_evt,
  output logic             underflow_evt
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  // wr_ptr_r is the next free slot, so the top entry sits one below it
  assign top_data      = mem_r[wr_ptr_r - PTR_ONE];
  assign empty         = (count_r == {CNT_W{1'b0}});
  assign full          = (count_r == CNT_FULL);
  assign overflow_evt  = push & ~pop & full;
  assign underflow_evt = pop & empty;

  // Storage, pointer and occupancy; pop takes precedence over push
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (pop) begin
      if (!empty) begin
        wr_ptr_r <= wr_ptr_r - PTR_ONE;
        count_r  <= count_r - CNT_ONE;
      end
    end else if (push) begin
      mem_r[wr_ptr_r] <= push_data;
      wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      if (!full) begin
        count_r <= count_r + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with call/return stack and sticky RAS error flags.
// Define PC_TRACE_EN to add the pc_prev and pc_src trace outputs.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                WIDTH        = DEF_WIDTH,
  parameter int                RAS_DEPTH    = DEF_RAS_DEPTH,
  parameter int                INC_STEP     = DEF_INC_STEP,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             stall,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc_pc,
  input  logic             con,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             err_clr,
`ifdef PC_TRACE_EN
  output logic [WIDTH-1:0] pc_prev,
  output logic [2:0]       pc_src,
`endif
  output logic [WIDTH-1:0] pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INC_STEP);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_nxt_s;
  logic [WIDTH-1:0] link_s;
  logic [WIDTH-1:0] top_s;
  pc_src_e          src_s;
  logic             push_s;
  logic             pop_s;
  logic             ovf_evt_s;
  logic             unf_evt_s;
  logic             ovf_r;
  logic             unf_r;

  assign link_s        = pc_r + STEP;
  assign pc            = pc_r;
  assign ras_overflow  = ovf_r;
  assign ras_underflow = unf_r;

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock         (clock),
    .clear         (clear),
    .push          (push_s),
    .pop           (pop_s),
    .push_data     (link_s),
    .top_data      (top_s),
    .empty         (ras_empty),
    .full          (ras_full),
    .overflow_evt  (ovf_evt_s),
    .underflow_evt (unf_evt_s)
  );

  // Priority selection: exactly one action per cycle; ret beats a concurrent call
  always_comb begin
    src_s  = PC_SRC_HOLD;
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (stall) begin
      src_s = PC_SRC_HOLD;
    end else if (load_en) begin
      src_s = PC_SRC_LOAD;
    end else if (ret_en) begin
      src_s = PC_SRC_RET;
      pop_s = 1'b1;
    end else if (call_en) begin
      src_s  = PC_SRC_CALL;
      push_s = 1'b1;
    end else if (jump_en) begin
      src_s = PC_SRC_JUMP;
    end else if (con) begin
      src_s = PC_SRC_BRANCH;
    end else if (inc_pc) begin
      src_s = PC_SRC_INC;
    end else begin
      src_s = PC_SRC_HOLD;
    end
  end

  // Next-pc datapath for the selected action
  always_comb begin
    pc_nxt_s = pc_r;
    case (src_s)
      PC_SRC_LOAD:   pc_nxt_s = load_value;
      PC_SRC_RET:    pc_nxt_s = ras_empty ? link_s : top_s;
      PC_SRC_CALL:   pc_nxt_s = jump_target;
      PC_SRC_JUMP:   pc_nxt_s = jump_target;
      PC_SRC_BRANCH: pc_nxt_s = pc_r + branch_offset;
      PC_SRC_INC:    pc_nxt_s = link_s;
      default:       pc_nxt_s = pc_r;
    endcase
  end

  // PC register and sticky flags; a same-cycle error event beats err_clr
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pc_r  <= RESET_VECTOR;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (!stall) begin
      pc_r  <= pc_nxt_s;
      ovf_r <= ovf_evt_s | (ovf_r & ~err_clr);
      unf_r <= unf_evt_s | (unf_r & ~err_clr);
    end
  end

`ifdef PC_TRACE_EN
  logic [WIDTH-1:0] pc_prev_r;
  logic [2:0]       pc_src_r;

  assign pc_prev = pc_prev_r;
  assign pc_src  = pc_src_r;

  // Trace of the previous pc and the action taken on the last edge
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pc_prev_r <= RESET_VECTOR;
      pc_src_r  <= PC_SRC_RESET;
    end else begin
      pc_src_r <= src_s;
      if (!stall) begin
        pc_prev_r <= pc_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_VECTOR = 0x100, RAS_DEPTH = 4).
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic        stall, load_en, inc_pc, con, jump_en, call_en, ret_en, err_clr;
  logic [31:0] load_value, branch_offset, jump_target;
  logic [31:0] pc;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;
`ifdef PC_TRACE_EN
  logic [31:0] pc_prev;
  logic [2:0]  pc_src;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pc_sequencer #(
    .WIDTH        (32),
    .RAS_DEPTH    (4),
    .INC_STEP     (1),
    .RESET_VECTOR (32'h100)
  ) dut (
    .clock         (clock),
    .clear         (clear),
    .stall         (stall),
    .load_en       (load_en),
    .load_value    (load_value),
    .inc_pc        (inc_pc),
    .con           (con),
    .branch_offset (branch_offset),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .err_clr       (err_clr),
`ifdef PC_TRACE_EN
    .pc_prev       (pc_prev),
    .pc_src        (pc_src),
`endif
    .pc            (pc),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  task automatic idle();
    stall = 1'b0; load_en = 1'b0; inc_pc = 1'b0; con = 1'b0;
    jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0; err_clr = 1'b0;
    load_value = 32'h0; branch_offset = 32'h0; jump_target = 32'h0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic load_pc(input logic [31:0] v);
    load_en = 1'b1; load_value = v;
    step();
  endtask

  task automatic do_call(input logic [31:0] t);
    call_en = 1'b1; jump_target = t;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    idle();
    clear = 1'b1;
    #2;
    checks++;
    if (pc !== 32'h100 || ras_empty !== 1'b1 || ras_full !== 1'b0 ||
        ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h empty=%b full=%b ovf=%b unf=%b required pc=100 empty=1 full=0 ovf=0 unf=0",
               pc, ras_empty, ras_full, ras_overflow, ras_underflow);
    end
`ifdef PC_TRACE_EN
    checks++;
    if (pc_src !== PC_SRC_RESET || pc_prev !== 32'h100) begin
      errors++;
      $display("FAIL reset_trace: pc_src=%0d pc_prev=%h required %0d 100", pc_src, pc_prev, PC_SRC_RESET);
    end
`endif
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
    exp_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      inc_pc = 1'b1;
      step();
      exp_pc = exp_pc + 32'h1;
      checks++;
      if (pc !== exp_pc) begin
        errors++;
        $display("FAIL inc_%0d: pc=%h required %h", i, pc, exp_pc);
      end
    end
    // clear mid-cycle with an increment pending: takes effect before any edge
    inc_pc = 1'b1;
    #2;
    clear = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h100) begin
      errors++;
      $display("FAIL async_clear: pc=%h required 100", pc);
    end
    clear = 1'b0;
    inc_pc = 1'b0;
    step();
    checks++;
    if (pc !== 32'h100) begin
      errors++;
      $display("FAIL post_clear_hold: pc=%h required 100", pc);
    end
  endtask

  task automatic test_branch_wrap();
    load_pc(32'h10);
    con = 1'b1; branch_offset = 32'hFFFF_FFFC;
    step();
    checks++;
    if (pc !== 32'h0C) begin
      errors++;
      $display("FAIL branch_neg: pc=%h required 0000000c", pc);
    end
    load_pc(32'hFFFF_FFFF);
    inc_pc = 1'b1;
    step();
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL inc_wrap: pc=%h required 00000000", pc);
    end
    jump_en = 1'b1; jump_target = 32'hABC0; inc_pc = 1'b1;
    step();
    checks++;
    if (pc !== 32'hABC0) begin
      errors++;
      $display("FAIL jump: pc=%h required 0000abc0", pc);
    end
  endtask

  task automatic test_call_ret();
    logic [31:0] exp_ret [3];
    exp_ret[0] = 32'h61; exp_ret[1] = 32'h41; exp_ret[2] = 32'h21;
    load_pc(32'h20);
    do_call(32'h40);
    do_call(32'h60);
    do_call(32'h80);
    checks++;
    if (pc !== 32'h80 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
      errors++;
      $display("FAIL call3: pc=%h empty=%b full=%b required 80 0 0", pc, ras_empty, ras_full);
    end
    for (int i = 0; i < 3; i++) begin
      ret_en = 1'b1;
      step();
      checks++;
      if (pc !== exp_ret[i]) begin
        errors++;
        $display("FAIL ret_%0d: pc=%h required %h", i, pc, exp_ret[i]);
      end
    end
    checks++;
    if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL ret_empty: empty=%b unf=%b required 1 0", ras_empty, ras_underflow);
    end
  endtask

  task automatic test_overflow_underflow();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h401; exp_ret[1] = 32'h301; exp_ret[2] = 32'h201; exp_ret[3] = 32'h101;
    load_pc(32'h0);
    for (int i = 1; i <= 5; i++) begin
      do_call(32'(i) << 8);
    end
    checks++;
    if (ras_overflow !== 1'b1 || ras_full !== 1'b1 || pc !== 32'h500) begin
      errors++;
      $display("FAIL overflow: ovf=%b full=%b pc=%h required 1 1 500", ras_overflow, ras_full, pc);
    end
    for (int i = 0; i < 4; i++) begin
      ret_en = 1'b1;
      step();
      checks++;
      if (pc !== exp_ret[i]) begin
        errors++;
        $display("FAIL ovf_ret_%0d: pc=%h required %h", i, pc, exp_ret[i]);
      end
    end
    // stalled pop on empty stack must not raise underflow
    stall = 1'b1; ret_en = 1'b1;
    step();
    checks++;
    if (ras_underflow !== 1'b0 || pc !== 32'h101) begin
      errors++;
      $display("FAIL stall_ret: unf=%b pc=%h required 0 101", ras_underflow, pc);
    end
    ret_en = 1'b1;
    step();
    checks++;
    if (pc !== 32'h102 || ras_underflow !== 1'b1 || ras_overflow !== 1'b1 || ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow: pc=%h unf=%b ovf=%b empty=%b required 102 1 1 1",
               pc, ras_underflow, ras_overflow, ras_empty);
    end
    err_clr = 1'b1;
    step();
    checks++;
    if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: ovf=%b unf=%b required 0 0", ras_overflow, ras_underflow);
    end
    // error event in the same cycle as err_clr: set wins
    ret_en = 1'b1; err_clr = 1'b1;
    step();
    checks++;
    if (ras_underflow !== 1'b1 || pc !== 32'h103) begin
      errors++;
      $display("FAIL set_wins: unf=%b pc=%h required 1 103", ras_underflow, pc);
    end
    err_clr = 1'b1;
    step();
  endtask

  task automatic test_conflicts();
    load_pc(32'h55);
    stall = 1'b1; load_en = 1'b1; load_value = 32'h999; inc_pc = 1'b1;
    step();
    checks++;
    if (pc !== 32'h55) begin
      errors++;
      $display("FAIL stall_hold: pc=%h required 55", pc);
    end
    load_en = 1'b1; load_value = 32'h700; con = 1'b1; branch_offset = 32'h8;
    step();
    checks++;
    if (pc !== 32'h700) begin
      errors++;
      $display("FAIL load_over_con: pc=%h required 700", pc);
    end
    load_pc(32'h32);
    do_call(32'h99);
    call_en = 1'b1; ret_en = 1'b1; jump_target = 32'h77;
    step();
    checks++;
    if (pc !== 32'h33 || ras_empty !== 1'b1 || ras_overflow !== 1'b0) begin
      errors++;
      $display("FAIL call_ret: pc=%h empty=%b ovf=%b required 33 1 0", pc, ras_empty, ras_overflow);
    end
  endtask

  task automatic test_trace();
`ifdef PC_TRACE_EN
    load_pc(32'h10);
    con = 1'b1; branch_offset = 32'hFFFF_FFFC;
    step();
    checks++;
    if (pc !== 32'h0C || pc_prev !== 32'h10 || pc_src !== PC_SRC_BRANCH) begin
      errors++;
      $display("FAIL trace_branch: pc=%h pc_prev=%h pc_src=%0d required c 10 %0d",
               pc, pc_prev, pc_src, PC_SRC_BRANCH);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_branch_wrap();
    test_call_ret();
    test_overflow_underflow();
    test_conflicts();
    test_trace();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
